axi4_to_axis_ipv4_reader: RTL and testbench
===========================================

Name: axi4_to_axis_ipv4_reader

Overview:
- Reads one IPv4 packet from memory over an AXI4 read master and streams it out as AXI-Stream; the return path for packets stored by the IPv4 AXIS-to-AXI4 writer.
- A command supplies the packet start address.
- The block reads the header beat, takes the IPv4 Total Length from it, then issues data bursts for the rest of the packet.
- Bursts are split at MAX_BURST beats and at 4 KB boundaries; the last beat carries the correct tkeep.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 512, AXI/AXIS data width; BEAT_BYTES = DATA_WIDTH/8.
- ID_WIDTH, 4, AXI ID width.
- MAX_BURST, 16, maximum beats per data burst (1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_addr  in  ADDR_WIDTH  packet start address; must be BEAT_BYTES-aligned
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(BEAT_BYTES), constant
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rid  in  ID_WIDTH  ignored
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  BEAT_BYTES  byte enables
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last beat of packet
- done  out  1  one-cycle pulse when the packet is fully sent
- err  out  1  one-cycle pulse on a bad rresp or an illegal length

Behaviour:
- Reset (asynchronous): state=IDLE.
  - All valids, m_axi_rready, done, err = 0; cmd_ready = 1.
  - araddr, arlen, tdata, tkeep = 0.
  - Reset mid-operation abandons the transaction immediately; the bench resets the slave too.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_addr into addr_q and go to HDR_AR.
- HDR_AR:
  - Drive arvalid with araddr=addr_q and arlen=0.
  - Hold arvalid until arready; on the handshake go to HDR_R.
- HDR_R:
  - rready=1; capture rdata into hdr_q.
  - Total length L = {rdata[23:16], rdata[31:24]} (IPv4 bytes 2..3, network order).
  - Compute beats = ceil(L/BEAT_BYTES) and beats_left = beats-1 (11-bit counters).
  - Set addr_q += BEAT_BYTES. Go to HDR_OUT.
- HDR_OUT:
  - Present hdr_q with tvalid=1, tlast=(beats_left==0).
  - tkeep = last-beat keep if tlast, else all ones.
  - Hold until tready. Then go to DONE if beats_left==0, otherwise DATA_AR.
- DATA_AR:
  - blen = min(MAX_BURST, beats_left, (4096 - addr_q[11:0])/BEAT_BYTES).
  - Drive arlen=blen-1, araddr=addr_q; hold until arready.
  - On the handshake: addr_q += blen*BEAT_BYTES, beats_left -= blen. Go to DATA_R.
- DATA_R:
  - Combinational pass-through: m_axis_tdata=rdata, m_axis_tvalid=rvalid, m_axi_rready=m_axis_tready.
  - tlast = rlast && beats_left==0.
  - tkeep = last-beat keep on the tlast beat, else all ones.
  - On an rlast handshake go to DONE if beats_left==0, otherwise DATA_AR.
  - Only one burst is outstanding at a time.
- Last-beat keep: r = L mod BEAT_BYTES; keep = all ones if r==0, else (1<<r)-1.
- DONE: done=1 for one cycle, then go to IDLE.
- Errors:
  - rresp != 2'b00 on any beat pulses err; the beat is still forwarded and the transfer completes.
  - L < 20 pulses err in HDR_R and forces beats=1: the header alone is sent with tlast=1 and tkeep all ones.
- Simultaneous events: cmd_valid outside IDLE is ignored (cmd_ready=0). arvalid is never dropped before arready.

Test Plan:
- cmd_addr=0x1000_0000, L=400, all readies high:
  - AR len 0 @0x1000_0000, then AR len 5 @0x1000_0040.
  - 7 AXIS beats; last tkeep=0x0000_0000_0000_FFFF with tlast; done pulses once.
- L=800 @0x1000_0000:
  - Second AR len 11 @0x1000_0040; 13 beats.
  - Last tkeep has the lower 32 bits set; no err.
- L=1500 @0x1000_0F80:
  - ARs: len 0 @0xF80, len 0 @0xFC0, len 15 @0x1000_1000, len 5 @0x1000_1400.
  - 24 beats; last tkeep has the lower 28 bits set.
- L=64:
  - Single AR; one beat with tlast=1 and tkeep all ones; no second AR.
- L=400 with random tready/arready/rvalid stalls (about 50%):
  - Data and order are identical to the unstalled run; arvalid is stable until arready.
- Faults:
  - rresp=2'b10 on beat 3 -> err pulse, packet still completes with done.
  - L=10 -> err pulse, one header beat with tlast.
  - rst_n low mid-DATA_R -> all outputs return to their reset values within the same cycle.

Source files
------------

// File: rtl/axi4_to_axis_ipv4_reader.sv
// AXI4 read master that fetches one stored IPv4 packet and replays it as
// an AXI-Stream packet. The header beat is read first to learn the IPv4
// Total Length. The rest of the packet is then fetched in INCR bursts that
// never exceed MAX_BURST beats and never cross a 4 KB page.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A valid raised by this block (arvalid,
// tvalid) is held, with stable payload, until its ready is seen. In DATA_R the
// R channel is forwarded combinationally: tvalid follows rvalid and rready
// follows tready, so one R beat moves on each R/AXIS handshake.
module axi4_to_axis_ipv4_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    done,
  output logic                    err
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BB_LOG     = $clog2(BEAT_BYTES);
  localparam logic [BEAT_BYTES-1:0] KEEP_ONE = {{(BEAT_BYTES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_AR  = 3'd1,
    S_HDR_R   = 3'd2,
    S_HDR_OUT = 3'd3,
    S_DATA_AR = 3'd4,
    S_DATA_R  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   hdr_q;
  logic [10:0]             beats_left;
  logic [BEAT_BYTES-1:0]   keep_last_q;

  // Header decode: IPv4 Total Length sits in bytes 2..3, network order.
  logic [15:0]             hdr_len;
  logic [16:0]             len_round;
  logic [10:0]             hdr_beats;
  logic                    hdr_short;
  logic [BB_LOG-1:0]       hdr_rem;
  logic [BEAT_BYTES-1:0]   keep_calc;

  assign hdr_len   = {m_axi_rdata[23:16], m_axi_rdata[31:24]};
  assign len_round = {1'b0, hdr_len} + 17'(BEAT_BYTES - 1);
  assign hdr_beats = 11'(len_round >> BB_LOG);
  assign hdr_short = (hdr_len < 16'd20);
  assign hdr_rem   = hdr_len[BB_LOG-1:0];
  assign keep_calc = (hdr_rem == '0) ? '1 : ((KEEP_ONE << hdr_rem) - KEEP_ONE);

  // Beats remaining before the next 4 KB page boundary.
  logic [12:0]             page_beats;
  logic [12:0]             blen;

  assign page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BB_LOG;

  // Burst length: the smallest of the burst cap, the remaining beats and the page room.
  always_comb begin
    blen = 13'(MAX_BURST);
    if ({2'b00, beats_left} < blen) blen = {2'b00, beats_left};
    if (page_beats < blen) blen = page_beats;
  end

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(BB_LOG);
  assign m_axi_arburst = 2'b01;

  // Response ID is not used: only one burst is ever outstanding.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  // State register plus the address, header and beat bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      hdr_q       <= '0;
      beats_left  <= '0;
      keep_last_q <= '1;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) addr_q <= cmd_addr;
        end
        S_HDR_R: begin
          if (m_axi_rvalid) begin
            hdr_q  <= m_axi_rdata;
            addr_q <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
            if (hdr_short) begin
              // A bogus length is not trusted: only the header goes out.
              beats_left  <= '0;
              keep_last_q <= '1;
            end else begin
              beats_left  <= hdr_beats - 11'd1;
              keep_last_q <= keep_calc;
            end
          end
        end
        S_DATA_AR: begin
          if (m_axi_arready) begin
            addr_q     <= addr_q + (ADDR_WIDTH'(blen) << BB_LOG);
            beats_left <= beats_left - blen[10:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and all handshake / stream outputs, decoded from the state.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arlen   = '0;
    m_axi_rready  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_HDR_AR;
      end
      S_HDR_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = addr_q;
        if (m_axi_arready) state_nxt = S_HDR_R;
      end
      S_HDR_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          err       = (m_axi_rresp != 2'b00) || hdr_short;
          state_nxt = S_HDR_OUT;
        end
      end
      S_HDR_OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q;
        m_axis_tlast  = (beats_left == '0);
        m_axis_tkeep  = m_axis_tlast ? keep_last_q : '1;
        if (m_axis_tready) state_nxt = (beats_left == '0) ? S_DONE : S_DATA_AR;
      end
      S_DATA_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = addr_q;
        m_axi_arlen   = 8'(blen - 13'd1);
        if (m_axi_arready) state_nxt = S_DATA_R;
      end
      S_DATA_R: begin
        m_axis_tdata  = m_axi_rdata;
        m_axis_tvalid = m_axi_rvalid;
        m_axi_rready  = m_axis_tready;
        m_axis_tlast  = m_axi_rlast && (beats_left == '0);
        m_axis_tkeep  = m_axis_tlast ? keep_last_q : '1;
        if (m_axi_rvalid && m_axis_tready) begin
          err = (m_axi_rresp != 2'b00);
          if (m_axi_rlast) state_nxt = (beats_left == '0) ? S_DONE : S_DATA_AR;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_to_axis_ipv4_reader.sv
// Bench for the IPv4 AXI4-to-AXIS reader: an AXI4 read slave backed by a
// synthetic memory, an AXIS sink, and queues of expected AR requests and
// stream beats filled by each test before its command is issued.
module tb_axi4_to_axis_ipv4_reader;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int KW = DW / 8;
  localparam int EW = DW + KW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] cmd_addr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          done;
  logic          err;

  // Clock
  always #5 clk = ~clk;

  axi4_to_axis_ipv4_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_addr      (cmd_addr),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .done          (done),
    .err           (err)
  );

  // Scoreboard state
  logic [EW-1:0]   exp_q[$];
  logic [AW+7:0]   exp_ar_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  int              done_cnt = 0;
  int              err_cnt = 0;
  int              beat_cnt = 0;
  logic [AW-1:0]   hdr_addr = '0;
  logic [15:0]     hdr_len = '0;
  bit              stall = 1'b0;
  int              bad_beat = -1;
  int              r_idx = 0;

  // Memory contents: address-derived pattern; the header word carries the length.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = (a ^ 32'hA5A5_5A5A) + 32'(i);
    if (a == hdr_addr) begin
      w[31:24] = hdr_len[7:0];
      w[23:16] = hdr_len[15:8];
    end
    return w;
  endfunction

  // Slave model, AXIS sink and output monitor. Sample at negedge, drive at posedge+1.
  initial begin
    logic [AW-1:0] rd_addr;
    int            rd_cnt;
    logic          ar_hs, r_hs, ar_pend;
    logic [AW-1:0] ar_a;
    logic [7:0]    ar_l;
    logic [AW+7:0] ar_prev, ar_exp;
    logic [EW-1:0] bexp;
    rd_addr = '0; rd_cnt = 0; ar_pend = 1'b0; ar_prev = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rid = '0; m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      ar_a  = m_axi_araddr;
      ar_l  = m_axi_arlen;
      if (rst_n) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (ar_pend) begin
          n_cmp++;
          if (m_axi_arvalid !== 1'b1 || {ar_a, ar_l} !== ar_prev) begin
            n_err++;
            $display("FAIL ar_stable: got valid=%b addr/len=%h required valid=1 addr/len=%h",
                     m_axi_arvalid, {ar_a, ar_l}, ar_prev);
          end
        end
        ar_pend = m_axi_arvalid && !m_axi_arready;
        ar_prev = {ar_a, ar_l};
        if (ar_hs) begin
          n_cmp++;
          if (exp_ar_q.size() == 0) begin
            n_err++;
            $display("FAIL ar_req: got addr=%h len=%0d required no request", ar_a, ar_l);
          end else begin
            ar_exp = exp_ar_q.pop_front();
            if ({ar_a, ar_l} !== ar_exp) begin
              n_err++;
              $display("FAIL ar_req: got addr=%h len=%0d required addr=%h len=%0d",
                       ar_a, ar_l, ar_exp[AW+7:8], ar_exp[7:0]);
            end
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beat_cnt++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL axis_beat: got keep=%h last=%b required no beat", m_axis_tkeep, m_axis_tlast);
          end else begin
            bexp = exp_q.pop_front();
            if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== bexp) begin
              n_err++;
              $display("FAIL axis_beat: got %h/%h/%b required %h/%h/%b",
                       m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                       bexp[EW-1:KW+1], bexp[KW:1], bexp[0]);
            end
          end
        end
      end else begin
        ar_pend = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rd_cnt = 0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        m_axi_arready = 1'b0; m_axis_tready = 1'b0;
      end else begin
        if (r_hs) begin
          r_idx++;
          rd_addr = rd_addr + AW'(KW);
          rd_cnt--;
        end
        if (ar_hs) begin
          rd_addr = ar_a;
          rd_cnt  = int'(ar_l) + 1;
        end
        m_axi_arready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axis_tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rd_cnt > 0) begin
          if (!(m_axi_rvalid && !r_hs)) m_axi_rvalid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
          m_axi_rdata = mem_word(rd_addr);
          m_axi_rlast = (rd_cnt == 1);
          m_axi_rresp = (r_idx == bad_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
      end
    end
  end

  // Driver: set up memory for a packet and reset the slave's beat index.
  task automatic setup_pkt(input logic [AW-1:0] base, input logic [15:0] len);
    hdr_addr = base;
    hdr_len  = len;
    r_idx    = 0;
  endtask

  // Driver: push the expected AXIS beats of one packet.
  task automatic push_beats(input logic [AW-1:0] base, input int n, input logic [KW-1:0] keep_last);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({mem_word(base + AW'(i * KW)),
                       (i == n - 1) ? keep_last : {KW{1'b1}},
                       (i == n - 1)});
    end
  endtask

  // Driver: issue one command, then wait for done or the cycle budget.
  task automatic run_cmd(input logic [AW-1:0] a, input int budget, output int cycles);
    int start;
    @(posedge clk); #1;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    start  = done_cnt;
    cycles = 0;
    while (done_cnt == start && cycles < budget) begin
      @(posedge clk);
      cycles++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, done, err} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 1000000",
               {cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, done, err});
    end
    n_cmp++;
    if ({m_axi_araddr, m_axi_arlen} !== '0) begin
      n_err++;
      $display("FAIL reset_ar: got addr=%h len=%0d required 0/0", m_axi_araddr, m_axi_arlen);
    end
    n_cmp++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
      n_err++;
      $display("FAIL reset_axis: got keep=%h required data/keep zero", m_axis_tkeep);
    end
    n_cmp++;
    if ({m_axi_arid, m_axi_arsize, m_axi_arburst} !== {4'h0, 3'd6, 2'b01}) begin
      n_err++;
      $display("FAIL ar_const: got id=%h size=%0d burst=%b required 0/6/01",
               m_axi_arid, m_axi_arsize, m_axi_arburst);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_l400();
    int d0, e0, cyc;
    setup_pkt(32'h1000_0000, 16'd400);
    exp_ar_q.push_back({32'h1000_0000, 8'd0});
    exp_ar_q.push_back({32'h1000_0040, 8'd5});
    push_beats(32'h1000_0000, 7, 64'h0000_0000_0000_FFFF);
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h1000_0000, 500, cyc);
    n_cmp++;
    if (cyc >= 500) begin n_err++; $display("FAIL l400_timeout: got %0d cycles required <500", cyc); end
    n_cmp++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL l400_pulses: got done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL l400_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_l800();
    int d0, e0, cyc;
    setup_pkt(32'h1000_0000, 16'd800);
    exp_ar_q.push_back({32'h1000_0000, 8'd0});
    exp_ar_q.push_back({32'h1000_0040, 8'd11});
    push_beats(32'h1000_0000, 13, 64'h0000_0000_FFFF_FFFF);
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h1000_0000, 500, cyc);
    n_cmp++;
    if (cyc >= 500 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL l800_pulses: got cyc=%0d done=%0d err=%0d required <500/1/0", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL l800_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_page_cross();
    int d0, e0, cyc;
    setup_pkt(32'h1000_0F80, 16'd1500);
    exp_ar_q.push_back({32'h1000_0F80, 8'd0});
    exp_ar_q.push_back({32'h1000_0FC0, 8'd0});
    exp_ar_q.push_back({32'h1000_1000, 8'd15});
    exp_ar_q.push_back({32'h1000_1400, 8'd5});
    push_beats(32'h1000_0F80, 24, 64'h0000_0000_0FFF_FFFF);
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h1000_0F80, 800, cyc);
    n_cmp++;
    if (cyc >= 800 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL page_pulses: got cyc=%0d done=%0d err=%0d required <800/1/0", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL page_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_single_beat();
    int d0, e0, cyc;
    setup_pkt(32'h2000_0000, 16'd64);
    exp_ar_q.push_back({32'h2000_0000, 8'd0});
    push_beats(32'h2000_0000, 1, {KW{1'b1}});
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h2000_0000, 200, cyc);
    n_cmp++;
    if (cyc >= 200 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL single_pulses: got cyc=%0d done=%0d err=%0d required <200/1/0", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL single_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_stall();
    int d0, e0, cyc;
    stall = 1'b1;
    setup_pkt(32'h1000_0000, 16'd400);
    exp_ar_q.push_back({32'h1000_0000, 8'd0});
    exp_ar_q.push_back({32'h1000_0040, 8'd5});
    push_beats(32'h1000_0000, 7, 64'h0000_0000_0000_FFFF);
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h1000_0000, 2000, cyc);
    stall = 1'b0;
    n_cmp++;
    if (cyc >= 2000 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL stall_pulses: got cyc=%0d done=%0d err=%0d required <2000/1/0", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_rresp_err();
    int d0, e0, cyc;
    setup_pkt(32'h3000_0000, 16'd400);
    bad_beat = 3;
    exp_ar_q.push_back({32'h3000_0000, 8'd0});
    exp_ar_q.push_back({32'h3000_0040, 8'd5});
    push_beats(32'h3000_0000, 7, 64'h0000_0000_0000_FFFF);
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h3000_0000, 500, cyc);
    bad_beat = -1;
    n_cmp++;
    if (cyc >= 500 || done_cnt - d0 !== 1 || err_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL rresp_pulses: got cyc=%0d done=%0d err=%0d required <500/1/1", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL rresp_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_short_len();
    int d0, e0, cyc;
    setup_pkt(32'h4000_0000, 16'd10);
    exp_ar_q.push_back({32'h4000_0000, 8'd0});
    push_beats(32'h4000_0000, 1, {KW{1'b1}});
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(32'h4000_0000, 200, cyc);
    n_cmp++;
    if (cyc >= 200 || done_cnt - d0 !== 1 || err_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL short_pulses: got cyc=%0d done=%0d err=%0d required <200/1/1", cyc, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL short_left: got beats=%0d ars=%0d outstanding required 0/0", exp_q.size(), exp_ar_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int b0, c, d0, cyc;
    setup_pkt(32'h1000_0000, 16'd800);
    exp_ar_q.push_back({32'h1000_0000, 8'd0});
    exp_ar_q.push_back({32'h1000_0040, 8'd11});
    push_beats(32'h1000_0000, 13, 64'h0000_0000_FFFF_FFFF);
    b0 = beat_cnt;
    @(posedge clk); #1;
    cmd_addr  = 32'h1000_0000;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    c = 0;
    while (beat_cnt - b0 < 3 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= 200) begin n_err++; $display("FAIL mid_reach: got %0d beats required 3", beat_cnt - b0); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, done, err} !== 7'b1000000) begin
      n_err++;
      $display("FAIL mid_reset_ctrl: got %b required 1000000",
               {cmd_ready, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast, done, err});
    end
    n_cmp++;
    if ({m_axi_araddr, m_axi_arlen} !== '0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
      n_err++;
      $display("FAIL mid_reset_data: got addr=%h len=%0d keep=%h required all zero",
               m_axi_araddr, m_axi_arlen, m_axis_tkeep);
    end
    exp_q.delete();
    exp_ar_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // A fresh packet after the abandoned one must go through cleanly.
    setup_pkt(32'h2000_0000, 16'd64);
    exp_ar_q.push_back({32'h2000_0000, 8'd0});
    push_beats(32'h2000_0000, 1, {KW{1'b1}});
    d0 = done_cnt;
    run_cmd(32'h2000_0000, 200, cyc);
    n_cmp++;
    if (cyc >= 200 || done_cnt - d0 !== 1 || exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_recover: got cyc=%0d done=%0d beats_left=%0d required <200/1/0",
               cyc, done_cnt - d0, exp_q.size());
    end
  endtask

  // Test sequence and final report
  initial begin
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    test_reset();
    test_l400();
    test_l800();
    test_page_cross();
    test_single_beat();
    test_stall();
    test_rresp_err();
    test_short_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
